pulse_train_gen: RTL
====================

# pulse_train_gen

Synthesizable, cycle-counted pulse-train and trigger generator driven by the free-running bench clock. An enable input `on` arms it. On each rising edge of `on` it waits a programmable delay, then emits a programmable number of high/low pulses on `signal`, then flags completion. It replaces behavioural `#`-delay pulse and trigger modelling with clock-accurate RTL, and feeds downstream logic that consumes `signal` and `done`.

## Interface
- CW, 8, width of every timing/count field and internal counter
- clock  input  1  rising-edge system clock
- clear  input  1  asynchronous, active-low reset
- on  input  1  arm level; a 0→1 transition (synchronously detected) starts a burst
- delay  input  CW  cycles between start and first high phase (D)
- high  input  CW  high-phase length in cycles (H); 0 treated as 1
- low  input  CW  low-phase length between pulses (L); 0 allowed
- count  input  CW  number of pulses per burst (N); 0 allowed
- signal  output  1  registered pulse-train output
- busy  output  1  high from burst start until DONE state exits
- done  output  1  one-cycle completion strobe

## Operation
- States: IDLE, DELAY, HIGH, LOW, DONE.
- Edge detect: `on_q` samples `on` every edge, including while busy. Start = `on & ~on_q` while in IDLE.
- On start edge: latch delay/high/low/count into internal registers and enter DELAY. Input changes after that edge do not affect the running burst.
- DELAY: lasts D+1 cycles (includes the latch cycle), then HIGH.
- HIGH: H' cycles, where H' = max(H,1). Then:
  - if pulses remaining > 0 → LOW; else → DONE.
- LOW: L cycles, then HIGH. If L = 0, LOW is skipped and consecutive high phases merge into one continuous high.
- N = 0: DELAY goes straight to DONE; `signal` never rises.
- DONE: exactly one cycle with `done`=1, then IDLE.
- `signal` = 1 only in HIGH. `busy` = 1 in DELAY, HIGH, LOW, DONE.
- Start edges arriving while not in IDLE are ignored, not queued.
- `on` held high: exactly one burst. A new burst needs `on` to go low, then high again.
- `on` falling mid-burst has no effect; the burst completes.
- All counters are CW bits, unsigned. Maximum field value is 2^CW−1, and no count may wrap inside a burst.

## Timing
- Reset (`clear`=0, asynchronous): state IDLE, `signal`=0, `busy`=0, `done`=0, `on_q`=0, counters 0. Takes effect immediately, mid-burst included. The first start is possible on the first rising edge after release where `on`=1 and `on_q`=0.
- `on` held high through reset release counts as a rising edge on the first clock after release.
- Start detected at edge k: `busy` high after edge k.
- `signal` first rises after edge k+D+1.
- Pulse i (0-based) is high after edges k+D+1+i·(H'+L) through k+D+i·(H'+L)+H'.
- `done` high for the cycle after edge T = k+D+1+N·H'+(N−1)·L for N ≥ 1, and T = k+D+1 for N = 0.
- `busy` falls and IDLE is re-entered after edge T+1. The earliest next start edge is T+1, if `on` rose during the DONE cycle.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- D=2, H=3, L=2, N=2, `on` rises before edge 0: `busy`↑ after edge 0; `signal` high after edges 3–5 and 8–10; `done` after edge 11 only; `busy`↓ after edge 12.
- N=0, D=4: `signal` stays 0; `done` after edge 5; `busy` high after edges 0–5.
- H=0, L=0, N=3, D=0: H treated as 1, so `signal` is continuously high after edges 1–3; `done` after edge 4.
- `on` held high for 300 cycles with D=1, H=2, L=1, N=1: exactly one burst (`signal` high after edges 2–3, `done` after 4). A second `on` pulse issued mid-burst produces no extra burst. A toggle of `on` during the DONE cycle starts a new burst at edge T+1.
- `clear` pulsed low during a HIGH phase: `signal`, `busy`, `done` drop to 0 immediately without a clock edge. After release, `on` 0→1 starts a fresh burst with the timing above.
- Max values, CW=8, D=255, H=255, L=255, N=2: first rise after edge 256; `done` after edge 256+510+255 = 1021; no wrap.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Cycle-counted pulse-train generator: each rising edge of `on` runs a burst of
// a programmable delay followed by N high/low pulses, then a one-cycle done strobe.
module pulse_train_gen #(
    parameter int unsigned CW = 8
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          on,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] high,
    input  logic [CW-1:0] low,
    input  logic [CW-1:0] count,
    output logic          signal,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          on_q, on_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] low_q, low_d;
    logic          signal_q, signal_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          start_c;

    // rem_q holds the pulses still to be emitted after the current high phase.
    always_comb begin
        state_d  = state_q;
        on_d     = on;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        high_d   = high_q;
        low_d    = low_q;
        start_c  = on & ~on_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE exits straight into a new burst if `on` rose during it
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start_c) begin
                    state_d = S_DELAY;
                    cnt_d   = delay;
                    rem_d   = count;
                    high_d  = (high == '0) ? CW'(1) : high;
                    low_d   = low;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        rem_d   = rem_q - CW'(1);
                        cnt_d   = high_q - CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else if (low_q == '0) begin
                        // zero-length low phase: back-to-back highs merge
                        state_d = S_HIGH;
                        rem_d   = rem_q - CW'(1);
                        cnt_d   = high_q - CW'(1);
                    end else begin
                        state_d = S_LOW;
                        cnt_d   = low_q - CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    rem_d   = rem_q - CW'(1);
                    cnt_d   = high_q - CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        signal_d = (state_d == S_HIGH);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            on_q     <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            high_q   <= '0;
            low_q    <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            on_q     <= on_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            high_q   <= high_d;
            low_q    <= low_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign signal = signal_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
